// File: rtl/training_sample_buffer_if.sv
// Host and datapath signals of the training sample buffer.
// The host drives the load and read requests. The buffer drives the handshake and the sample vectors.
interface training_sample_buffer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned L1     = 2,
    parameter int unsigned L4     = 1
);
    logic                             load_start;
    logic                             wr_valid;
    logic [DATA_W-1:0]                wr_data;
    logic                             wr_ready;
    logic                             load_done;
    logic                             buf_ready;
    logic                             rd_en;
    logic [DATA_W-1:0]                rd_addr;
    logic [0:L1-1][0:0][DATA_W-1:0]   a1;
    logic [0:L4-1][0:0][DATA_W-1:0]   y;
    logic                             out_valid;
    logic                             addr_err;

    modport master (
        output load_start, wr_valid, wr_data, rd_en, rd_addr,
        input  wr_ready, load_done, buf_ready, a1, y, out_valid, addr_err
    );

    modport slave (
        input  load_start, wr_valid, wr_data, rd_en, rd_addr,
        output wr_ready, load_done, buf_ready, a1, y, out_valid, addr_err
    );
endinterface

// File: rtl/training_sample_buffer.sv
// Training set store.
// The host loads the buffer word by word in sample-major order.
// The buffer then serves one sample (input vector a1 and label y) per read, with 1-cycle latency.
module training_sample_buffer #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned L1        = 2,
    parameter int unsigned L4        = 1,
    parameter int unsigned N_SAMPLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    training_sample_buffer_if.slave  bus
);
    localparam int unsigned WPS   = L1 + L4;
    localparam int unsigned TOTAL = N_SAMPLES * WPS;
    localparam int unsigned SW    = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
    localparam int unsigned EW    = (WPS > 1) ? $clog2(WPS) : 1;

    localparam logic [SW-1:0]     S_LAST   = SW'(N_SAMPLES - 1);
    localparam logic [EW-1:0]     E_LAST   = EW'(WPS - 1);
    localparam logic [DATA_W-1:0] N_LIMIT  = DATA_W'(N_SAMPLES);

    typedef logic [0:L1-1][0:0][DATA_W-1:0] a1_vec_t;
    typedef logic [0:L4-1][0:0][DATA_W-1:0] y_vec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READY
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [EW-1:0] e_q, e_d;
    logic          load_done_q, load_done_d;
    logic          out_valid_q, out_valid_d;
    logic          addr_err_q, addr_err_d;
    a1_vec_t       a1_q, a1_d;
    y_vec_t        y_q, y_d;

    // Sample storage is deliberately left out of reset.
    a1_vec_t       a1_mem [N_SAMPLES];
    y_vec_t        y_mem  [N_SAMPLES];

    logic          wr_ready;
    logic          wr_accept;
    logic          rd_fire;
    logic          rd_in_range;
    logic [SW-1:0] rd_idx;

    // Handshake and read qualification.
    // A load_start in the same cycle blocks the write and the read.
    always_comb begin
        wr_ready    = (state_q == ST_LOAD) && !bus.load_start;
        wr_accept   = wr_ready && bus.wr_valid;
        rd_fire     = bus.rd_en && (state_q == ST_READY) && !bus.load_start;
        rd_in_range = (bus.rd_addr < N_LIMIT);
        rd_idx      = bus.rd_addr[SW-1:0];
    end

    // Next-state logic for the load FSM and the sample/element counters.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        e_d         = e_q;
        load_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.load_start) begin
                    state_d = ST_LOAD;
                    s_d     = '0;
                    e_d     = '0;
                end
            end
            ST_LOAD: begin
                if (bus.load_start) begin
                    // Abort: restart the load from word 0. The words already stored remain in place.
                    s_d = '0;
                    e_d = '0;
                end else if (wr_accept) begin
                    if (e_q == E_LAST) begin
                        e_d = '0;
                        if (s_q == S_LAST) begin
                            state_d     = ST_READY;
                            s_d         = '0;
                            load_done_d = 1'b1;
                        end else begin
                            s_d = s_q + 1'b1;
                        end
                    end else begin
                        e_d = e_q + 1'b1;
                    end
                end
            end
            ST_READY: begin
                if (bus.load_start) begin
                    state_d = ST_LOAD;
                    s_d     = '0;
                    e_d     = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                s_d     = '0;
                e_d     = '0;
            end
        endcase
    end

    // Read path.
    // Outputs hold between reads. An out-of-range address sets the sticky error flag.
    always_comb begin
        a1_d        = a1_q;
        y_d         = y_q;
        out_valid_d = 1'b0;
        addr_err_d  = addr_err_q;
        if (rd_fire) begin
            if (rd_in_range) begin
                a1_d        = a1_mem[rd_idx];
                y_d         = y_mem[rd_idx];
                out_valid_d = 1'b1;
            end else begin
                addr_err_d  = 1'b1;
            end
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            e_q         <= '0;
            load_done_q <= 1'b0;
            out_valid_q <= 1'b0;
            addr_err_q  <= 1'b0;
            a1_q        <= '0;
            y_q         <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            e_q         <= e_d;
            load_done_q <= load_done_d;
            out_valid_q <= out_valid_d;
            addr_err_q  <= addr_err_d;
            a1_q        <= a1_d;
            y_q         <= y_d;
        end
    end

    // Sample storage write.
    // Elements below L1 go to the input vector. The remaining elements go to the label.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int unsigned i = 0; i < L1; i++) begin
                if (e_q == EW'(i)) begin
                    a1_mem[s_q][i][0] <= bus.wr_data;
                end
            end
            for (int unsigned j = 0; j < L4; j++) begin
                if (e_q == EW'(L1 + j)) begin
                    y_mem[s_q][j][0] <= bus.wr_data;
                end
            end
        end
    end

    assign bus.wr_ready  = wr_ready;
    assign bus.load_done = load_done_q;
    assign bus.buf_ready = (state_q == ST_READY);
    assign bus.a1        = a1_q;
    assign bus.y         = y_q;
    assign bus.out_valid = out_valid_q;
    assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_training_sample_buffer.sv
// Bench for training_sample_buffer.
// A flat word-array reference model of the training set is checked cycle by cycle against the buffer.
module tb_training_sample_buffer;
    localparam int unsigned DW    = 32;
    localparam int unsigned L1    = 2;
    localparam int unsigned L4    = 1;
    localparam int unsigned NS    = 4;
    localparam int unsigned WPS   = L1 + L4;
    localparam int unsigned TOTAL = NS * WPS;

    logic clk = 1'b0;
    logic reset = 1'b1;

    training_sample_buffer_if #(.DATA_W(DW), .L1(L1), .L4(L4)) bus ();

    training_sample_buffer #(
        .DATA_W    (DW),
        .L1        (L1),
        .L4        (L4),
        .N_SAMPLES (NS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a flat word image plus the load/ready status.
    logic [DW-1:0]      m_mem [TOTAL];
    int unsigned        m_k;
    bit                 m_loading, m_ready, m_err, m_done, m_ov;
    logic [L1*DW-1:0]   m_a1;
    logic [L4*DW-1:0]   m_y;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_k = 0; m_loading = 0; m_ready = 0; m_err = 0;
        m_done = 0; m_ov = 0; m_a1 = '0; m_y = '0;
    endtask

    task automatic check_regs();
        check("load_done", bus.load_done, m_done);
        check("out_valid", bus.out_valid, m_ov);
        check("addr_err",  bus.addr_err,  m_err);
        check("a1",        bus.a1,        m_a1);
        check("y",         bus.y,         m_y);
        check("buf_ready", bus.buf_ready, m_ready);
    endtask

    // One clock cycle with the given inputs. The model is advanced and all outputs are compared.
    task automatic step(input bit ld, input bit wv, input logic [DW-1:0] wd,
                        input bit rd, input logic [DW-1:0] ad);
        bit was_ready;
        int unsigned a;
        bus.load_start = ld;
        bus.wr_valid   = wv;
        bus.wr_data    = wd;
        bus.rd_en      = rd;
        bus.rd_addr    = ad;
        #1;
        check("wr_ready",      bus.wr_ready,  m_loading && !ld);
        check("buf_ready_pre", bus.buf_ready, m_ready);
        was_ready = m_ready;
        m_done = 0;
        m_ov   = 0;
        if (ld) begin
            m_loading = 1; m_ready = 0; m_k = 0;
        end else if (m_loading && wv) begin
            m_mem[m_k] = wd;
            m_k++;
            if (m_k == TOTAL) begin
                m_loading = 0; m_ready = 1; m_done = 1; m_k = 0;
            end
        end
        if (was_ready && rd && !ld) begin
            if (ad < NS) begin
                a = ad;
                for (int unsigned i = 0; i < L1; i++) m_a1[(L1-1-i)*DW +: DW] = m_mem[a*WPS + i];
                for (int unsigned j = 0; j < L4; j++) m_y[(L4-1-j)*DW +: DW] = m_mem[a*WPS + L1 + j];
                m_ov = 1;
            end else begin
                m_err = 1;
            end
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, '0);
    endtask

    task automatic rd(input logic [DW-1:0] ad);
        step(0, 0, '0, 1, ad);
    endtask

    task automatic full_load(input logic [DW-1:0] base, input bit gaps);
        step(1, 0, '0, 0, '0);
        for (int unsigned w = 0; w < TOTAL; w++) begin
            step(0, 1, base + DW'(w), 0, '0);
            if (gaps && w < TOTAL - 1) step(0, 0, 32'hDEAD_0000 + DW'(w), 0, '0);
        end
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_wr_ready",  bus.wr_ready,  1'b0);
        check_regs();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.load_start = 0; bus.wr_valid = 0; bus.wr_data = '0;
        bus.rd_en = 0; bus.rd_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_ready", bus.wr_ready, 1'b0);
        check_regs();
        reset = 1'b0;

        // Gapless load, followed by reads.
        full_load(32'h10, 0);
        rd(2);
        check("a1_addr2", bus.a1, {32'h16, 32'h17});
        check("y_addr2",  bus.y,  32'h18);
        idle(1);
        for (int unsigned a = 0; a < NS; a++) rd(a);
        idle(1);

        // Out-of-range reads, followed by a valid read.
        rd(4);
        rd(32'hFFFF_FFFF);
        rd(1);
        check("a1_addr1", bus.a1, {32'h13, 32'h14});
        check("y_addr1",  bus.y,  32'h15);
        check("err_sticky", bus.addr_err, 1'b1);

        // Load with toggling valid, then read everything back.
        full_load(32'h50, 1);
        for (int unsigned a = 0; a < NS; a++) rd(a);

        // Abort after 5 words, then a complete reload.
        step(1, 0, '0, 0, '0);
        for (int unsigned w = 0; w < 5; w++) step(0, 1, 32'h30 + DW'(w), 0, '0);
        full_load(32'h20, 0);
        rd(0);
        check("a1_reload", bus.a1, {32'h20, 32'h21});
        check("y_reload",  bus.y,  32'h22);

        // Simultaneous load_start and read in READY: the read is dropped.
        step(1, 1, 32'h99, 1, 32'd1);
        idle(1);

        // Reset in the middle of a load. A read in IDLE is ignored. A full reload restores service.
        step(1, 0, '0, 0, '0);
        for (int unsigned w = 0; w < 7; w++) step(0, 1, 32'h70 + DW'(w), 0, '0);
        async_reset();
        rd(0);
        step(0, 1, 32'h1234, 1, 32'd9);
        full_load(32'h80, 0);
        rd(3);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            logic [DW-1:0] ad;
            ad = ($urandom_range(0, 24) == 0) ? DW'($urandom) : DW'($urandom_range(0, NS - 1));
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, DW'($urandom),
                 $urandom_range(0, 1) == 1, ad);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/training_sample_buffer.md
Name: training_sample_buffer

Overview:
- Stores the training set (input vectors and labels) loaded word-by-word from the host.
- Serves one sample per request to the network datapath: a1[0:L1-1][0:0] and y[0:L4-1][0:0].
- Sits directly upstream of top_neural_network. Its rd_addr input is driven by the state machine's address output.
- Gates training start: the host must not assert enable until buf_ready is high.

Parameters:
- DATA_W, 32, width of one data_type element (fixed-point word).
- L1, 2, input-layer size (elements per input vector).
- L4, 1, output-layer size (elements per label vector).
- N_SAMPLES, 4, number of training samples held.
- WPS (localparam), L1+L4, words per sample.
- TOTAL (localparam), N_SAMPLES*WPS, words per full load.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_start  in  1  one-cycle pulse; begins (or restarts) a full load.
- wr_valid  in  1  host write word valid.
- wr_data  in  DATA_W  host write word.
- wr_ready  out  1  buffer accepts the word this cycle.
- load_done  out  1  pulses for 1 cycle when the last word is accepted.
- buf_ready  out  1  complete training set resident; reads allowed.
- rd_en  in  1  read request.
- rd_addr  in  DATA_W  sample index; only the low clog2(N_SAMPLES) bits are used after the range check.
- a1  out  DATA_W x [0:L1-1][0:0]  input vector of the last valid read.
- y  out  DATA_W x [0:L4-1][0:0]  label vector of the last valid read.
- out_valid  out  1  pulses for 1 cycle when a1/y update.
- addr_err  out  1  sticky flag; an out-of-range read occurred.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; word counters cleared.
  - All outputs 0: a1, y, wr_ready, load_done, buf_ready, out_valid, addr_err.
  - Storage array is not cleared.
- State machine (IDLE, LOAD, READY):
  - IDLE -> LOAD on load_start.
  - LOAD -> READY when word TOTAL-1 is accepted.
  - READY -> LOAD on load_start.
  - LOAD -> LOAD on load_start: abort, counters reset to 0, words already stored are kept but the load restarts.
- Write handshake:
  - wr_ready = (state==LOAD) && !load_start (combinational).
  - A word is accepted when wr_valid && wr_ready.
  - The accepted word goes to sample s, element e.
    - e < L1: word is input element a1[e].
    - e >= L1: word is label element y[e-L1].
  - Counter update: e increments; when e==WPS-1, e wraps to 0 and s increments.
  - Order is sample-major: sample 0 elements 0..WPS-1, then sample 1, and so on.
  - wr_valid outside LOAD is ignored (wr_ready=0); nothing is stored.
  - load_done=1 in the cycle after the final word is accepted. buf_ready rises in that same cycle.
- buf_ready = (state==READY). It drops in the cycle after load_start is sampled.
- Read path (1-cycle latency):
  - Sampled when rd_en && buf_ready.
  - If rd_addr < N_SAMPLES: next cycle a1/y hold that sample's vectors and out_valid=1.
  - If rd_addr >= N_SAMPLES (full DATA_W compare, unsigned): addr_err sets and stays set until reset; a1/y hold; out_valid=0.
  - rd_en while !buf_ready: ignored. No out_valid, no addr_err.
  - Back-to-back reads are allowed every cycle; each valid read produces out_valid one cycle later.
  - a1/y hold their last value between reads, and also during a reload.
- Simultaneous events:
  - load_start and rd_en in READY: the read is ignored; the reload wins.
  - load_start and wr_valid in LOAD: the word is not accepted (wr_ready=0); the counters restart.
- Reset mid-load: state returns to IDLE, buf_ready=0. A complete new load is required before buf_ready rises again.

Test Plan (L1=2, L4=1, N_SAMPLES=4, TOTAL=12):
- Reset then full load of words 0x10..0x1B with wr_valid held high -> wr_ready high for 12 cycles; load_done pulses exactly once, in the cycle after the 0x1B accept; buf_ready=1 from that cycle on.
- Read rd_addr=2 -> next cycle a1={0x16,0x17}, y={0x18}, out_valid=1 for 1 cycle. Back-to-back reads of addr 0,1,2,3 -> four consecutive out_valid pulses with the matching vectors.
- Read rd_addr=4, then rd_addr=0xFFFFFFFF -> addr_err=1 and stays 1; a1/y unchanged; no out_valid. A subsequent valid read of addr 1 still returns {0x13,0x14},{0x15}.
- Load with wr_valid toggling 1/0 every cycle -> exactly 12 accepts over 23 cycles; stored contents identical to the gapless load.
- load_start after 5 words, then 12 words 0x20..0x2B -> buf_ready only after the 12th word of the second load; read addr 0 returns {0x20,0x21},{0x22}.
- Assert reset during LOAD (word 7), and separately rd_en in IDLE -> all outputs 0, state IDLE, no out_valid; a subsequent full load restores buf_ready.
